// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit -- parametrised program counter for the CPU datapath.
//
// Holds the PC and applies one command per cycle from the sequencer:
//   jump      : pc <= {data_in zero-extended into the upper lanes, lo_latch}
//   load_lane : overwrite one DATA_W-wide lane of the PC
//   branch    : 6502-style relative branch.
//               The low lane is updated at once.
//               If the offset carries across a page boundary, the upper lanes
//               are corrected one cycle later in the FIXUP state.
//   inc       : pc <= pc + 1, with a wrap pulse when pc was all-ones
// latch_lo captures data_in in every state so a jump target's low byte can be
// staged ahead of the jump itself.
//
// Handshake: there is no valid/ready pairing here.
//   The command strobes are sampled on every posedge while busy is low.
//   While busy is high, every strobe except latch_lo is dropped.
//   The sequencer must use busy to stall or reissue.
//
// Ports
//   clk, reset   clock; synchronous active-high reset
//   data_in      lane value / jump high byte / signed branch offset
//   lane_sel     lane index for load_lane (out-of-range index is a no-op)
//   load_lane, latch_lo, jump, inc, branch   command strobes
//   pc           registered program counter
//   busy         1 while in FIXUP; this is the FSM state bit itself
//   page_cross   registered pulse, cycle after a page-crossing branch
//   wrap         registered pulse, cycle after inc wrapped all-ones -> 0
// -----------------------------------------------------------------------------
module pc_unit #(
  parameter int unsigned          DATA_W    = 8,
  parameter int unsigned          ADDR_W    = 16,
  parameter logic [ADDR_W-1:0]    RESET_VEC = 16'hFFFC,
  localparam int unsigned         LANES     = ADDR_W / DATA_W,
  localparam int unsigned         LANE_W    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic [LANE_W-1:0] lane_sel,
  input  logic              load_lane,
  input  logic              latch_lo,
  input  logic              jump,
  input  logic              inc,
  input  logic              branch,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              page_cross,
  output logic              wrap
);

  localparam int unsigned UP_W = ADDR_W - DATA_W;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FIXUP = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic              dir_up_q, dir_up_d;      // FIXUP direction: 1 = +1 page, 0 = -1 page
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] lo_latch_q, lo_latch_d;
  logic              page_cross_q, page_cross_d;
  logic              wrap_q, wrap_d;

  // Low-lane add with carry out. The carry is read together with the offset sign
  // to decide whether the branch left the current page.
  logic [DATA_W:0]   lo_sum;
  logic [UP_W-1:0]   upper_q;

  assign lo_sum  = {1'b0, pc_q[DATA_W-1:0]} + {1'b0, data_in};
  assign upper_q = pc_q[ADDR_W-1:DATA_W];

  always_comb begin
    pc_d         = pc_q;
    state_d      = ST_IDLE;
    dir_up_d     = dir_up_q;
    page_cross_d = 1'b0;
    wrap_d       = 1'b0;
    // The latch updates in any state. A jump in the same cycle still reads
    // lo_latch_q, which is the old value.
    lo_latch_d   = latch_lo ? data_in : lo_latch_q;

    case (state_q)
      ST_IDLE: begin
        if (jump) begin
          pc_d                      = '0;
          pc_d[DATA_W-1:0]          = lo_latch_q;
          pc_d[2*DATA_W-1:DATA_W]   = data_in;
        end else if (load_lane) begin
          // A lane index with no matching lane leaves the PC unchanged.
          for (int i = 0; i < int'(LANES); i++) begin
            if (int'(lane_sel) == i) begin
              pc_d[i*DATA_W +: DATA_W] = data_in;
            end
          end
        end else if (branch) begin
          pc_d[DATA_W-1:0] = lo_sum[DATA_W-1:0];
          if (!data_in[DATA_W-1] && lo_sum[DATA_W]) begin
            state_d      = ST_FIXUP;
            dir_up_d     = 1'b1;
            page_cross_d = 1'b1;
          end else if (data_in[DATA_W-1] && !lo_sum[DATA_W]) begin
            state_d      = ST_FIXUP;
            dir_up_d     = 1'b0;
            page_cross_d = 1'b1;
          end
        end else if (inc) begin
          pc_d   = pc_q + 1'b1;
          wrap_d = (pc_q == '1);
        end
      end

      ST_FIXUP: begin
        // This state lasts one cycle. Commands other than latch_lo are dropped here.
        if (dir_up_q) pc_d[ADDR_W-1:DATA_W] = upper_q + 1'b1;
        else          pc_d[ADDR_W-1:DATA_W] = upper_q - 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      dir_up_q     <= 1'b0;
      pc_q         <= RESET_VEC;
      lo_latch_q   <= '0;
      page_cross_q <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir_up_q     <= dir_up_d;
      pc_q         <= pc_d;
      lo_latch_q   <= lo_latch_d;
      page_cross_q <= page_cross_d;
      wrap_q       <= wrap_d;
    end
  end

  assign pc         = pc_q;
  assign busy       = (state_q == ST_FIXUP);
  assign page_cross = page_cross_q;
  assign wrap       = wrap_q;

endmodule
